// File: rtl/burst_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// burst_cmd_scheduler
//
// Sequences start/end-of-burst and periodic bunch-counter-reset commands for the
// trigger processor and shares one downstream command channel (TTC broadcast
// serialiser) between them and a software requester.
//
// Fixed priority (evaluated only when idle): SOB > EOB > BCR (in run) > software.
// Every accepted command is followed by CMD_GAP idle clocks.
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active low
//   burst        asynchronous BURST level (synchronised internally)
//   sw_req       software command request (level)
//   sw_cmd       software command byte, stable while sw_req=1
//   sw_ack       one-cycle pulse, the clock after the software command transfers
//   cmd_valid    command available downstream
//   cmd_code     command byte, stable while cmd_valid=1
//   cmd_ready    downstream accept
//   in_run       high from SOB acceptance to EOB acceptance
//   bc_count     run-time bunch counter, free-running from SOB
//   bcr_overrun  sticky: a BCR fell due while the previous one was still pending
// -----------------------------------------------------------------------------
module burst_cmd_scheduler #(
  parameter int         BC_PERIOD = 3564,
  parameter int         CMD_GAP   = 44,
  parameter logic [7:0] CODE_SOB  = 8'h07,
  parameter logic [7:0] CODE_EOB  = 8'h0A,
  parameter logic [7:0] CODE_BCR  = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        burst,
  input  logic        sw_req,
  input  logic [7:0]  sw_cmd,
  output logic        sw_ack,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  input  logic        cmd_ready,
  output logic        in_run,
  output logic [11:0] bc_count,
  output logic        bcr_overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  typedef enum logic [1:0] {SRC_SOB, SRC_EOB, SRC_BCR, SRC_SW} src_t;

  localparam int                 GAP_W    = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD = (CMD_GAP > 0) ? GAP_W'(CMD_GAP - 1) : '0;
  localparam logic [11:0]        BC_LAST  = 12'(BC_PERIOD - 1);

  // ---------------------------------------------------------------------------
  // BURST synchroniser and edge detector.
  // vld tracks how far real samples have propagated since reset release, so a
  // level that is already high at release is not mistaken for a rising edge.
  // ---------------------------------------------------------------------------
  logic       sync1, sync2, burst_d;
  logic [2:0] vld;
  logic       rise, fall;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      burst_d <= 1'b0;
      vld     <= '0;
    end else begin
      sync1   <= burst;
      sync2   <= sync1;
      burst_d <= sync2;
      vld     <= {vld[1:0], 1'b1};
    end
  end

  assign rise = vld[2] &  sync2 & ~burst_d;
  assign fall = vld[2] & ~sync2 &  burst_d;

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  src_t             src, sel_src;
  logic [7:0]       sel_code;
  logic [GAP_W-1:0] gap_cnt;
  logic             pend_sob, pend_eob, pend_bcr;
  logic             req_any, xfer;
  logic             sob_xfer, eob_xfer, bcr_xfer, sw_xfer;

  assign cmd_valid = (state == ISSUE);
  assign xfer      = cmd_valid & cmd_ready;
  assign sob_xfer  = xfer & (src == SRC_SOB);
  assign eob_xfer  = xfer & (src == SRC_EOB);
  assign bcr_xfer  = xfer & (src == SRC_BCR);
  assign sw_xfer   = xfer & (src == SRC_SW);
  assign req_any   = pend_sob | pend_eob | (pend_bcr & in_run) | sw_req;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    sel_src  = SRC_SW;
    sel_code = sw_cmd;
    if (pend_sob) begin
      sel_src  = SRC_SOB;
      sel_code = CODE_SOB;
    end else if (pend_eob) begin
      sel_src  = SRC_EOB;
      sel_code = CODE_EOB;
    end else if (pend_bcr && in_run) begin
      sel_src  = SRC_BCR;
      sel_code = CODE_BCR;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ISSUE;
      ISSUE:   if (xfer)    state_nxt = (CMD_GAP == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Winner code and source are captured only on IDLE->ISSUE, so the held
  // command cannot be disturbed by later requests or sw_cmd changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_code <= '0;
      src      <= SRC_SW;
      gap_cnt  <= '0;
      sw_ack   <= 1'b0;
    end else begin
      sw_ack <= sw_xfer;
      if (state == IDLE && req_any) begin
        cmd_code <= sel_code;
        src      <= sel_src;
      end
      if (xfer)
        gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flags, run state and bunch counter.
  // A new edge wins over the clear of the same flag so it is never lost;
  // a repeated edge on an already-set flag simply merges.
  // ---------------------------------------------------------------------------
  logic bc_wrap;
  assign bc_wrap = in_run & (bc_count == BC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_sob    <= 1'b0;
      pend_eob    <= 1'b0;
      pend_bcr    <= 1'b0;
      in_run      <= 1'b0;
      bc_count    <= '0;
      bcr_overrun <= 1'b0;
    end else begin
      if (rise)          pend_sob <= 1'b1;
      else if (sob_xfer) pend_sob <= 1'b0;

      if (fall)          pend_eob <= 1'b1;
      else if (eob_xfer) pend_eob <= 1'b0;

      if (sob_xfer)      in_run <= 1'b1;
      else if (eob_xfer) in_run <= 1'b0;

      // BCR transfers do not touch bc_count: the period runs from SOB.
      if (sob_xfer || eob_xfer) bc_count <= '0;
      else if (bc_wrap)         bc_count <= '0;
      else if (in_run)          bc_count <= bc_count + 12'd1;

      if (sob_xfer || eob_xfer) pend_bcr <= 1'b0;
      else if (bc_wrap)         pend_bcr <= 1'b1;
      else if (bcr_xfer)        pend_bcr <= 1'b0;

      if (sob_xfer)                 bcr_overrun <= 1'b0;
      else if (bc_wrap && pend_bcr) bcr_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_burst_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_burst_cmd_scheduler
//
// Two instances: dut_a (default BC_PERIOD, CMD_GAP=4) for burst/software
// sequencing and reset, dut_b (BC_PERIOD=8, CMD_GAP=2) for periodic BCR and
// overrun. Inputs change on the falling edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_burst_cmd_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        burst_a, sw_req_a, cmd_ready_a, sw_ack_a, cmd_valid_a, in_run_a, bcr_overrun_a;
  logic [7:0]  sw_cmd_a, cmd_code_a;
  logic [11:0] bc_count_a;
  logic        burst_b, sw_req_b, cmd_ready_b, sw_ack_b, cmd_valid_b, in_run_b, bcr_overrun_b;
  logic [7:0]  sw_cmd_b, cmd_code_b;
  logic [11:0] bc_count_b;

  burst_cmd_scheduler #(.CMD_GAP(4)) dut_a (
    .clk(clk), .reset(reset), .burst(burst_a), .sw_req(sw_req_a), .sw_cmd(sw_cmd_a),
    .sw_ack(sw_ack_a), .cmd_valid(cmd_valid_a), .cmd_code(cmd_code_a),
    .cmd_ready(cmd_ready_a), .in_run(in_run_a), .bc_count(bc_count_a),
    .bcr_overrun(bcr_overrun_a)
  );

  burst_cmd_scheduler #(.BC_PERIOD(8), .CMD_GAP(2)) dut_b (
    .clk(clk), .reset(reset), .burst(burst_b), .sw_req(sw_req_b), .sw_cmd(sw_cmd_b),
    .sw_ack(sw_ack_b), .cmd_valid(cmd_valid_b), .cmd_code(cmd_code_b),
    .cmd_ready(cmd_ready_b), .in_run(in_run_b), .bc_count(bc_count_b),
    .bcr_overrun(bcr_overrun_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transfer log filled by collect(): code and cycle index of each accepted
  // command, plus the cycle index of each sw_ack pulse.
  int xfer_code[$];
  int xfer_cyc[$];
  int ack_cyc[$];

  function automatic int qcode(input int i);
    return (i < xfer_code.size()) ? xfer_code[i] : -1;
  endfunction

  function automatic int qcyc(input int i);
    return (i < xfer_cyc.size()) ? xfer_cyc[i] : -1;
  endfunction

  function automatic int qack(input int i);
    return (i < ack_cyc.size()) ? ack_cyc[i] : -1;
  endfunction

  // Samples first, then advances one clock; software drops sw_req on its ack.
  task automatic collect(input bit use_b, input int ncyc);
    xfer_code.delete();
    xfer_cyc.delete();
    ack_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (use_b) begin
        if (cmd_valid_b && cmd_ready_b) begin
          xfer_code.push_back(int'(cmd_code_b));
          xfer_cyc.push_back(c);
        end
      end else begin
        if (cmd_valid_a && cmd_ready_a) begin
          xfer_code.push_back(int'(cmd_code_a));
          xfer_cyc.push_back(c);
        end
        if (sw_ack_a) begin
          ack_cyc.push_back(c);
          sw_req_a = 1'b0;
        end
      end
      tick();
    end
  endtask

  typedef struct {
    logic        burst;
    logic        cmd_ready;
    logic        exp_valid;
    logic [7:0]  exp_code;
    logic        exp_in_run;
    logic [11:0] exp_bc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic b, input logic v, input logic [7:0] c,
                              input logic r, input logic [11:0] bc);
    vec_t t;
    t.burst      = b;
    t.cmd_ready  = 1'b1;
    t.exp_valid  = v;
    t.exp_code   = c;
    t.exp_in_run = r;
    t.exp_bc     = bc;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Per-clock vectors for dut_a after release with burst high:
    // fall -> EOB without run, rise -> SOB, fall -> EOB ending the run.
    for (int i = 0; i < 3; i++)  vecs[i] = mk(1'b0, 1'b0, 8'h00, 1'b0, 12'd0);
    vecs[3] = mk(1'b0, 1'b1, 8'h0A, 1'b0, 12'd0);
    for (int i = 4; i < 9; i++)  vecs[i] = mk(1'b0, 1'b0, 8'h00, 1'b0, 12'd0);
    for (int i = 9; i < 12; i++) vecs[i] = mk(1'b1, 1'b0, 8'h00, 1'b0, 12'd0);
    vecs[12] = mk(1'b1, 1'b1, 8'h07, 1'b0, 12'd0);
    vecs[13] = mk(1'b1, 1'b0, 8'h00, 1'b1, 12'd0);
    for (int i = 14; i < 18; i++) vecs[i] = mk(1'b1, 1'b0, 8'h00, 1'b1, 12'(i - 13));
    for (int i = 18; i < 21; i++) vecs[i] = mk(1'b0, 1'b0, 8'h00, 1'b1, 12'(i - 13));
    vecs[21] = mk(1'b0, 1'b1, 8'h0A, 1'b1, 12'd8);
    vecs[22] = mk(1'b0, 1'b0, 8'h00, 1'b0, 12'd0);
    vecs[23] = mk(1'b0, 1'b0, 8'h00, 1'b0, 12'd0);

    reset       = 1'b0;
    burst_a     = 1'b1;
    sw_req_a    = 1'b0;
    sw_cmd_a    = 8'h00;
    cmd_ready_a = 1'b1;
    burst_b     = 1'b0;
    sw_req_b    = 1'b0;
    sw_cmd_b    = 8'h00;
    cmd_ready_b = 1'b1;

    // ---- reset held with burst high ----
    repeat (3) tick();
    check("rst cmd_valid",   cmd_valid_a,   1'b0);
    check("rst cmd_code",    cmd_code_a,    8'h00);
    check("rst sw_ack",      sw_ack_a,      1'b0);
    check("rst in_run",      in_run_a,      1'b0);
    check("rst bc_count",    bc_count_a,    12'd0);
    check("rst bcr_overrun", bcr_overrun_a, 1'b0);
    check("rst b cmd_valid", cmd_valid_b,   1'b0);

    // ---- release with burst already high: no edge, no SOB ----
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("release c%0d cmd_valid", i), cmd_valid_a, 1'b0);
    end
    check("release in_run", in_run_a, 1'b0);

    // ---- table: EOB without run, SOB, EOB ----
    for (int i = 0; i < 24; i++) begin
      burst_a     = vecs[i].burst;
      cmd_ready_a = vecs[i].cmd_ready;
      tick();
      check($sformatf("vec%0d cmd_valid", i), cmd_valid_a, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d cmd_code", i), cmd_code_a, vecs[i].exp_code);
      check($sformatf("vec%0d in_run", i),   in_run_a,   vecs[i].exp_in_run);
      check($sformatf("vec%0d bc_count", i), bc_count_a, vecs[i].exp_bc);
      check($sformatf("vec%0d sw_ack", i),   sw_ack_a,   1'b0);
    end

    // ---- software request arriving with the SOB pend flag: SOB wins ----
    repeat (6) tick();
    burst_a = 1'b1;
    repeat (3) tick();
    sw_req_a = 1'b1;
    sw_cmd_a = 8'h5A;
    collect(1'b0, 20);
    check("swpri n_xfer",  xfer_code.size(), 2);
    check("swpri first",   qcode(0), 8'h07);
    check("swpri second",  qcode(1), 8'h5A);
    check("swpri sob cyc", qcyc(0),  1);
    check("swpri sw cyc",  qcyc(1),  7);
    check("swpri n_ack",   ack_cyc.size(), 1);
    check("swpri ack cyc", qack(0),  8);
    check("swpri in_run",  in_run_a, 1'b1);

    // ---- end the run ----
    burst_a = 1'b0;
    collect(1'b0, 14);
    check("eob n_xfer", xfer_code.size(), 1);
    check("eob code",   qcode(0), 8'h0A);
    check("eob cyc",    qcyc(0),  4);
    check("eob in_run", in_run_a, 1'b0);

    // ---- 1-clock burst pulse while a software command holds the channel ----
    sw_cmd_a    = 8'h3C;
    sw_req_a    = 1'b1;
    cmd_ready_a = 1'b0;
    tick();
    tick();
    check("pulse held valid", cmd_valid_a, 1'b1);
    check("pulse held code",  cmd_code_a,  8'h3C);
    burst_a = 1'b1;
    tick();
    burst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("pulse hold c%0d", i), {cmd_valid_a, cmd_code_a}, {1'b1, 8'h3C});
    end
    cmd_ready_a = 1'b1;
    collect(1'b0, 30);
    check("pulse n_xfer",  xfer_code.size(), 3);
    check("pulse code0",   qcode(0), 8'h3C);
    check("pulse code1",   qcode(1), 8'h07);
    check("pulse code2",   qcode(2), 8'h0A);
    check("pulse cyc0",    qcyc(0),  0);
    check("pulse cyc1",    qcyc(1),  6);
    check("pulse cyc2",    qcyc(2),  12);
    check("pulse n_ack",   ack_cyc.size(), 1);
    check("pulse ack cyc", qack(0),  1);
    check("pulse in_run",  in_run_a, 1'b0);

    // ---- dut_b: periodic BCR every 8 clocks ----
    burst_b = 1'b1;
    collect(1'b1, 50);
    check("bcr n_xfer", xfer_code.size(), 6);
    check("bcr sob",    qcode(0), 8'h07);
    check("bcr sob cyc", qcyc(0), 4);
    for (int i = 1; i < 6; i++) begin
      check($sformatf("bcr%0d code", i), qcode(i), 8'h01);
      check($sformatf("bcr%0d cyc", i),  qcyc(i),  14 + 8 * (i - 1));
    end
    check("bcr no overrun", bcr_overrun_b, 1'b0);

    // ---- dut_b: stall the channel, BCR held, overrun sets ----
    cmd_ready_b = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (seen)
          check($sformatf("bcr hold c%0d", i), {cmd_valid_b, cmd_code_b}, {1'b1, 8'h01});
        else if (cmd_valid_b) begin
          seen = 1'b1;
          check("bcr held code", cmd_code_b, 8'h01);
        end
      end
      check("bcr held seen", seen, 1'b1);
    end
    check("bcr overrun set", bcr_overrun_b, 1'b1);

    cmd_ready_b = 1'b1;
    burst_b     = 1'b0;
    repeat (14) tick();
    check("bcr eob in_run",     in_run_b,      1'b0);
    check("bcr eob keeps ovr",  bcr_overrun_b, 1'b1);
    burst_b = 1'b1;
    repeat (7) tick();
    check("bcr sob in_run",     in_run_b,      1'b1);
    check("bcr sob clears ovr", bcr_overrun_b, 1'b0);

    // ---- reset asserted while a software command is held ----
    burst_a     = 1'b1;
    cmd_ready_a = 1'b1;
    repeat (10) tick();
    check("rsti in_run", in_run_a, 1'b1);
    sw_cmd_a    = 8'h99;
    sw_req_a    = 1'b1;
    cmd_ready_a = 1'b0;
    repeat (3) tick();
    check("rsti held valid", cmd_valid_a, 1'b1);
    check("rsti held code",  cmd_code_a,  8'h99);
    #2 reset = 1'b0;
    #1;
    check("rsti async valid", cmd_valid_a, 1'b0);
    check("rsti async in_run", in_run_a,   1'b0);
    check("rsti async bc",    bc_count_a,  12'd0);
    check("rsti async ack",   sw_ack_a,    1'b0);
    @(negedge clk);
    sw_req_a = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rsto c%0d valid/ack", i), {cmd_valid_a, sw_ack_a}, 2'b00);
    end
    check("rsto in_run", in_run_a,   1'b0);
    check("rsto bc",     bc_count_a, 12'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
